downselect_mask_ctrl: RTL and testbench
=======================================

Name: downselect_mask_ctrl

Overview:
- Owns a 2048-bit channel-enable mask shadow, stored as 64 x 32-bit words.
- Accepts per-channel set/clear, clear-all and commit commands.
- On commit, streams all 64 mask words (tlast on word 63) into the select-FIFO AXI-Stream port of the channelizer downselection stage.
- Sits between the register/control plane and downselect_2048. It sequences mask loads so downselection sees only complete, atomic mask updates, aligned to a frame boundary when required.

Parameters:
- SYNC_COMMIT, 1, 1 = commit stream waits for frame_sync pulse; 0 = stream starts immediately.
- NUM_WORDS, 64, mask words per commit (fixed 64 for 2048 channels; other values unsupported).

Ports:
- clk  in  1  system clock
- sync_reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_op  in  2  0=SET chan, 1=CLR chan, 2=CLEAR_ALL, 3=COMMIT
- cmd_chan  in  11  channel index (SET/CLR only)
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- frame_sync  in  1  single-cycle frame-boundary pulse (eob from datapath)
- m_axis_select_tvalid  out  1  mask word valid
- m_axis_select_tdata  out  32  mask word
- m_axis_select_tlast  out  1  high on word 63
- m_axis_select_tready  in  1  downstream ready
- busy  out  1  high in every state except IDLE
- commit_count  out  16  completed commits, wraps at 0xFFFF->0

Behaviour:
- One clock: clk. Reset: sync_reset, synchronous, active-high. All flops sample reset only on the rising edge of clk.
- Reset values: cmd_ready=0, busy=1, m_axis_select_tvalid=0, tlast=0, tdata=0, commit_count=0, state=CLEAR, clear address=0.
- Mask mapping: channel c lives in word c[10:5], bit c[4:0]. Word n therefore covers mask bits 32n+31..32n.
- Storage: 64x32 RAM with 1-cycle registered read. Inferred distributed or block RAM.
- FSM states: IDLE, CLEAR, RMW_RD, RMW_WR, WAIT_SYNC, STREAM.
- IDLE:
  - cmd_ready=1, busy=0.
  - On accept: SET/CLR -> RMW_RD, latching op and chan. CLEAR_ALL -> CLEAR, addr=0. COMMIT -> WAIT_SYNC if SYNC_COMMIT=1, else STREAM.
  - cmd_ready=0 in all other states. No command queuing.
- CLEAR:
  - Writes 0 to words 0..63, one per cycle: 64 cycles, then IDLE.
  - Also entered from reset, so the mask is all-zero after reset completes (65 cycles until cmd_ready=1).
- RMW_RD: issue read of word chan[10:5]; 1 cycle.
- RMW_WR:
  - Write back the read word with bit chan[4:0] set (SET) or cleared (CLR); then IDLE.
  - SET/CLR latency: 2 cycles of cmd_ready low.
  - Setting an already-set bit, or clearing a clear bit, leaves the word unchanged.
- WAIT_SYNC: hold until frame_sync=1, then STREAM. A frame_sync arriving while in IDLE is ignored (not remembered).
- STREAM:
  - Words 0..63 are presented in order with AXI-Stream rules.
  - tdata/tlast must hold stable while tvalid & ~tready.
  - A word is consumed only on tvalid & tready.
  - With tready held high, all 64 words transfer on 64 consecutive cycles; first tvalid is asserted 1 cycle after entering STREAM (read latency).
  - Read-ahead must tolerate arbitrary tready toggling with no word skipped or duplicated.
  - tlast=1 only on word 63.
  - On the handshake of word 63: commit_count += 1, go to IDLE, tvalid deasserts the next cycle.
- Mask contents are frozen during STREAM, since commands are blocked. The streamed image is exactly the mask at commit acceptance.
- Reset mid-operation (any state, including mid-stream): immediately apply reset values and re-run CLEAR. Downstream receives a truncated packet without tlast. downselect_2048 restarts its load at word 0 on the next packet (its new_mask is reset alongside), so this is acceptable.
- No arithmetic beyond a 6-bit word counter (wraps 63->0 only via state exit) and the 16-bit commit counter.

Test Plan:
- Reset -> cmd_ready stays 0 for 65 cycles then rises; COMMIT with tready=1 streams 64 words all 0x00000000, tlast only on 64th, commit_count=1.
- SET ch 0, 31, 32, 2047; COMMIT -> word0=0x80000001, word1=0x00000001, word63=0x80000000, all others 0.
- After the above, CLR ch 31 then SET ch 5; COMMIT -> word0=0x00000021; then CLEAR_ALL + COMMIT -> all zero, commit_count=3.
- SYNC_COMMIT=1: COMMIT accepted, frame_sync withheld 100 cycles -> tvalid stays 0, busy=1; frame_sync pulse -> tvalid rises next cycle.
- Random tready (50% duty) during stream of a pseudo-random mask -> captured 64 words match the model exactly, tdata stable while stalled, one tlast.
- sync_reset asserted at word 20 of a stream -> tvalid=0 next cycle, commit_count=0, subsequent COMMIT streams all-zero mask.

Source files
------------

// File: rtl/downselect_mask_ctrl_if.sv
// Command and select-stream bundles for downselect_mask_ctrl.
// cmd carries SET/CLR/CLEAR_ALL/COMMIT; axis carries the mask words.
interface dsm_cmd_if;
  logic        valid;
  logic [1:0]  op;
  logic [10:0] chan;
  logic        ready;

  modport master (
    output valid, op, chan,
    input  ready
  );
  modport slave (
    input  valid, op, chan,
    output ready
  );
endinterface

interface dsm_axis_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (
    output tvalid, tdata, tlast,
    input  tready
  );
  modport slave (
    input  tvalid, tdata, tlast,
    output tready
  );
endinterface

// File: rtl/downselect_mask_ctrl.sv
// 2048-channel enable-mask shadow with atomic, optionally
// frame-aligned commit streaming into the downselect select FIFO.
module downselect_mask_ctrl #(
  parameter bit SYNC_COMMIT = 1'b1,
  parameter int NUM_WORDS   = 64
) (
  input  logic        clk,
  input  logic        sync_reset,
  dsm_cmd_if.slave    cmd,
  input  logic        frame_sync,
  dsm_axis_if.master  m_axis_select,
  output logic        busy,
  output logic [15:0] commit_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RMW_RD,
    S_RMW_WR,
    S_WAIT_SYNC,
    S_STREAM
  } state_t;

  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_CLR = 2'd1;
  localparam logic [1:0] OP_CLA = 2'd2;
  localparam logic [5:0] LAST_W = 6'(NUM_WORDS - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_mem [0:63];
  logic [31:0] r_rdata;
  logic [5:0]  r_addr;
  logic [5:0]  w_addr_nx;
  logic        r_op_clr;
  logic [10:0] r_chan;
  logic        r_tvalid;
  logic [15:0] r_count;

  logic        w_acc;
  logic        w_xfer;
  logic        w_last;
  logic        w_we;
  logic [5:0]  w_waddr;
  logic [5:0]  w_raddr;
  logic [31:0] w_wdata;
  logic [31:0] w_bit;

  assign cmd.ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_acc     = cmd.valid & cmd.ready;
  assign w_xfer    = r_tvalid & m_axis_select.tready;
  assign w_last    = (r_addr == LAST_W);
  assign w_bit     = 32'd1 << r_chan[4:0];

  assign m_axis_select.tvalid = r_tvalid;
  assign m_axis_select.tdata  = r_rdata;
  assign m_axis_select.tlast  = r_tvalid & w_last;
  assign commit_count         = r_count;

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_we       = 1'b0;
    w_waddr    = r_addr;
    w_wdata    = '0;
    w_raddr    = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (cmd.op)
            OP_SET, OP_CLR: w_state_nx = S_RMW_RD;
            OP_CLA: begin
              w_state_nx = S_CLEAR;
              w_addr_nx  = '0;
            end
            default: begin
              w_state_nx = SYNC_COMMIT ? S_WAIT_SYNC
                                       : S_STREAM;
              w_addr_nx  = '0;
            end
          endcase
        end
      end
      S_CLEAR: begin
        w_we      = 1'b1;
        w_addr_nx = r_addr + 6'd1;
        if (w_last) w_state_nx = S_IDLE;
      end
      S_RMW_RD: begin
        w_raddr    = r_chan[10:5];
        w_state_nx = S_RMW_WR;
      end
      S_RMW_WR: begin
        w_we       = 1'b1;
        w_waddr    = r_chan[10:5];
        w_wdata    = r_op_clr ? (r_rdata & ~w_bit)
                              : (r_rdata | w_bit);
        w_state_nx = S_IDLE;
      end
      S_WAIT_SYNC: begin
        if (frame_sync) w_state_nx = S_STREAM;
      end
      S_STREAM: begin
        // Re-read the presented word while stalled so tdata
        // stays put; step the read address on each handshake.
        if (w_xfer) begin
          if (w_last) w_state_nx = S_IDLE;
          else        w_addr_nx  = r_addr + 6'd1;
        end
        w_raddr = w_addr_nx;
      end
      default: begin
        w_state_nx = S_CLEAR;
        w_addr_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state  <= S_CLEAR;
      r_addr   <= '0;
      r_op_clr <= 1'b0;
      r_chan   <= '0;
      r_tvalid <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_addr   <= w_addr_nx;
      r_tvalid <= (r_state == S_STREAM)
                & ~(w_xfer & w_last);
      if (w_acc) begin
        r_op_clr <= (cmd.op == OP_CLR);
        r_chan   <= cmd.chan;
      end
      if (r_state == S_STREAM && w_xfer && w_last)
        r_count <= r_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) r_rdata <= '0;
    else            r_rdata <= r_mem[w_raddr];
  end

endmodule

// File: tb/tb_downselect_mask_ctrl.sv
// Self-checking bench for downselect_mask_ctrl: directed table,
// frame-sync and reset corners, random masks against a bit-level model.
module tb_downselect_mask_ctrl;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        frame_sync;
  logic        busy;
  logic [15:0] commit_count;

  always #5 clk = ~clk;

  dsm_cmd_if  cmd_if ();
  dsm_axis_if ax_if ();

  downselect_mask_ctrl #(
    .SYNC_COMMIT (1'b1),
    .NUM_WORDS   (64)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .cmd           (cmd_if),
    .frame_sync    (frame_sync),
    .m_axis_select (ax_if),
    .busy          (busy),
    .commit_count  (commit_count)
  );

  typedef struct {
    logic [1:0]  op;
    logic [10:0] chan;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w63;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mdl [2048];
  logic [31:0] exp_img [64];
  logic [31:0] cap [64];
  int          ncap, nlast, lastidx, stab_err;
  logic [15:0] exp_commits;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int n);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[b] = mdl[32 * n + b];
    return w;
  endfunction

  // Starts and ends just after a falling edge.
  task automatic send_cmd(input logic [1:0] op,
                          input logic [10:0] chan);
    int n;
    n = 0;
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.chan  = chan;
    while (!cmd_if.ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_if.ready) chk("cmd_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_if.valid = 1'b0;
    case (op)
      2'd0: mdl[chan] = 1'b1;
      2'd1: mdl[chan] = 1'b0;
      2'd2: for (int i = 0; i < 2048; i++) mdl[i] = 1'b0;
      default:
        for (int w = 0; w < 64; w++) exp_img[w] = mdl_word(w);
    endcase
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic do_commit(input int dly);
    send_cmd(2'd3, 11'd0);
    repeat (dly) @(negedge clk);
    pulse_fs();
  endtask

  task automatic run_stream(input int duty, input int stop_at);
    int          cyc;
    bit          stalled;
    logic [31:0] st_data;
    logic        st_last;
    ncap = 0; nlast = 0; lastidx = -1; stab_err = 0;
    cyc = 0; stalled = 1'b0; st_data = '0; st_last = 1'b0;
    while (ncap < stop_at && cyc < 3000) begin
      ax_if.tready = ($urandom_range(99) < duty);
      if (ax_if.tvalid) begin
        if (stalled && (ax_if.tdata !== st_data ||
                        ax_if.tlast !== st_last))
          stab_err++;
        if (ax_if.tready) begin
          cap[ncap] = ax_if.tdata;
          if (ax_if.tlast) begin
            nlast++;
            lastidx = ncap;
          end
          ncap++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          st_data = ax_if.tdata;
          st_last = ax_if.tlast;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    ax_if.tready = 1'b0;
    if (cyc >= 3000) chk("stream_timeout", 32'(ncap), 32'(stop_at));
  endtask

  task automatic check_stream(input string tag);
    int nmis;
    nmis = 0;
    for (int w = 0; w < 64; w++)
      if (cap[w] !== exp_img[w]) begin
        if (nmis == 0)
          $display("FAIL %s word%0d act=%h exp=%h",
                   tag, w, cap[w], exp_img[w]);
        nmis++;
      end
    exp_commits = exp_commits + 16'd1;
    chk({tag, "_mismatch_words"}, 32'(nmis), 32'd0);
    chk({tag, "_ncap"}, 32'(ncap), 32'd64);
    chk({tag, "_tlast_cnt"}, 32'(nlast), 32'd1);
    chk({tag, "_tlast_idx"}, 32'(lastidx), 32'd63);
    chk({tag, "_stall_stable"}, 32'(stab_err), 32'd0);
    chk({tag, "_tvalid_drop"}, {31'd0, ax_if.tvalid}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_commit_cnt"}, {16'd0, commit_count},
        {16'd0, exp_commits});
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_clear_cycles"}, 32'(n), 32'd64);
  endtask

  task automatic random_ops(input int cnt);
    logic [1:0] op;
    for (int i = 0; i < cnt; i++) begin
      op = ($urandom_range(99) < 65) ? 2'd0 : 2'd1;
      send_cmd(op, 11'($urandom_range(2047)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int   n;
    int   viol;
    tbl[0] = '{2'd0, 11'd0,    '0, '0, '0};
    tbl[1] = '{2'd0, 11'd31,   '0, '0, '0};
    tbl[2] = '{2'd0, 11'd32,   '0, '0, '0};
    tbl[3] = '{2'd0, 11'd2047, '0, '0, '0};
    tbl[4] = '{2'd3, 11'd0, 32'h8000_0001, 32'h1, 32'h8000_0000};
    tbl[5] = '{2'd1, 11'd31,   '0, '0, '0};
    tbl[6] = '{2'd0, 11'd5,    '0, '0, '0};
    tbl[7] = '{2'd3, 11'd0, 32'h0000_0021, 32'h1, 32'h8000_0000};
    tbl[8] = '{2'd2, 11'd0,    '0, '0, '0};

    sync_reset   = 1'b1;
    frame_sync   = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.op    = '0;
    cmd_if.chan  = '0;
    ax_if.tready = 1'b0;
    exp_commits  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_if.ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_tvalid", {31'd0, ax_if.tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, ax_if.tlast}, 32'd0);
    chk("rst_tdata", ax_if.tdata, 32'd0);
    chk("rst_count", {16'd0, commit_count}, 32'd0);
    sync_reset = 1'b0;
    wait_ready("rst");

    do_commit(2);
    run_stream(100, 64);
    check_stream("zero");

    for (int v = 0; v < 9; v++) begin
      if (tbl[v].op != 2'd3) begin
        send_cmd(tbl[v].op, tbl[v].chan);
      end else begin
        do_commit(v % 3);
        run_stream(100, 64);
        check_stream($sformatf("tbl%0d", v));
        chk($sformatf("tbl%0d_w0", v), cap[0], tbl[v].w0);
        chk($sformatf("tbl%0d_w1", v), cap[1], tbl[v].w1);
        chk($sformatf("tbl%0d_w63", v), cap[63], tbl[v].w63);
      end
    end
    do_commit(1);
    run_stream(100, 64);
    check_stream("clrall");

    send_cmd(2'd0, 11'd100);
    n = 0;
    while (!cmd_if.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_latency", 32'(n), 32'd2);
    send_cmd(2'd0, 11'd100);
    send_cmd(2'd1, 11'd101);

    pulse_fs();
    repeat (3) @(negedge clk);
    send_cmd(2'd3, 11'd0);
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      if (ax_if.tvalid || !busy || cmd_if.ready) viol++;
      @(negedge clk);
    end
    chk("sync_hold", 32'(viol), 32'd0);
    pulse_fs();
    @(posedge clk);
    @(negedge clk);
    chk("sync_tvalid_rise", {31'd0, ax_if.tvalid}, 32'd1);
    run_stream(100, 64);
    check_stream("sync");

    for (int r = 0; r < 4; r++) begin
      random_ops(40);
      if (r == 2) send_cmd(2'd2, 11'd0);
      if (r == 2) random_ops(10);
      do_commit($urandom_range(5));
      run_stream(50, 64);
      check_stream($sformatf("rnd%0d", r));
    end

    random_ops(20);
    do_commit(0);
    run_stream(100, 20);
    chk("mid_ncap", 32'(ncap), 32'd20);
    sync_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_tvalid", {31'd0, ax_if.tvalid}, 32'd0);
    chk("mid_tlast", {31'd0, ax_if.tlast}, 32'd0);
    chk("mid_count", {16'd0, commit_count}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    sync_reset = 1'b0;
    for (int i = 0; i < 2048; i++) mdl[i] = 1'b0;
    exp_commits = '0;
    wait_ready("mid");
    do_commit(1);
    run_stream(50, 64);
    check_stream("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
